// File: rtl/inv_input_network.sv
// inv_input_network: recovers the original challenge from the output of the
// forward XOR-PUF input network, one bit per cycle, then un-rotates it.
// Handshake on both sides (valid/ready); x_out is held in a register.
// Optional build macro: INV_INPUT_NETWORK_CNT_EN adds a saturating 16-bit
// count of completed output handshakes on port done_cnt.
module inv_input_network #(
    parameter int N      = 64,
    parameter int NSHIFT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x_out,
    output logic         busy
`ifdef INV_INPUT_NETWORK_CNT_EN
    ,
    output logic [15:0]  done_cnt
`endif
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] STEP_LAST = SW'(N - 1);
    localparam logic [SW-1:0] HALF      = SW'(N / 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECOVER = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [N-1:0]  y_r;
    logic [N-1:0]  z_r;
    logic [N-1:0]  x_r;
    logic [SW-1:0] step_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          busy_r;

    logic          accept_s;
    logic          out_hs_s;
    logic          last_step_s;
    logic [SW-1:0] i_s;
    logic [SW-1:0] half_i_s;
    logic [SW-1:0] idx_s;
    logic          new_bit_s;

    // x[j] = z[(j + NSHIFT) mod N]: undoes the forward rotation.
    function automatic logic [N-1:0] unrotate(input logic [N-1:0] z);
        logic [N-1:0] x;
        x = {N{1'b0}};
        for (int j = 0; j < N; j++) begin
            x[j] = z[(j + NSHIFT) % N];
        end
        return x;
    endfunction

    assign accept_s    = in_valid & in_ready_r & (state_r == ST_IDLE);
    assign out_hs_s    = out_valid_r & out_ready;
    assign last_step_s = (step_r == STEP_LAST);

    // Next z bit: z[step] = z[step-1] ^ y[idx], idx depends on parity of step-1.
    always_comb begin
        i_s      = step_r - SW'(1);
        half_i_s = {1'b0, i_s[SW-1:1]};
        if (i_s[0] == 1'b0) begin
            idx_s = half_i_s;
        end else begin
            idx_s = HALF + half_i_s + SW'(1);
        end
        new_bit_s = z_r[i_s] ^ y_r[idx_s];
    end

    // Next-state decode of the IDLE -> RECOVER -> DONE -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RECOVER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RECOVER;
                end
            end
            ST_DONE: begin
                if (out_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: capture, bit-serial recovery, output latch and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r         <= {N{1'b0}};
            z_r         <= {N{1'b0}};
            x_r         <= {N{1'b0}};
            step_r      <= {SW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r     <= (state_nxt_s == ST_RECOVER);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        y_r    <= y_in;
                        z_r    <= {{(N-1){1'b0}}, y_in[N/2]};
                        step_r <= SW'(1);
                    end
                end
                ST_RECOVER: begin
                    z_r[step_r] <= new_bit_s;
                    if (!last_step_s) begin
                        step_r <= step_r + SW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_hs_s) begin
                        out_valid_r <= 1'b0;
                    end else if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        x_r         <= unrotate(z_r);
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef INV_INPUT_NETWORK_CNT_EN
    logic [15:0] done_cnt_r;

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_r <= 16'h0000;
        end else if (out_hs_s && (done_cnt_r != 16'hFFFF)) begin
            done_cnt_r <= done_cnt_r + 16'h0001;
        end
    end

    assign done_cnt = done_cnt_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign x_out     = x_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_inv_input_network.sv
// Bench for inv_input_network: two N=8 instances (NSHIFT 0 and 1) share one
// stimulus stream; one N=64, NSHIFT=5 instance runs random round trips.
module tb_inv_input_network;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_in_valid, a_out_ready;
    logic [7:0]  a_y;
    logic        a_in_ready, a_out_valid, a_busy;
    logic [7:0]  a_x;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [7:0]  b_x;
    logic        c_in_valid, c_out_ready;
    logic [63:0] c_y, c_x;
    logic        c_in_ready, c_out_valid, c_busy;
`ifdef INV_INPUT_NETWORK_CNT_EN
    logic [15:0] a_cnt, b_cnt, c_cnt;
    int          a_hs = 0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    inv_input_network #(.N(8), .NSHIFT(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .y_in(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .x_out(a_x), .busy(a_busy)
`ifdef INV_INPUT_NETWORK_CNT_EN
        , .done_cnt(a_cnt)
`endif
    );

    inv_input_network #(.N(8), .NSHIFT(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(b_in_ready),
        .y_in(a_y), .out_valid(b_out_valid), .out_ready(a_out_ready),
        .x_out(b_x), .busy(b_busy)
`ifdef INV_INPUT_NETWORK_CNT_EN
        , .done_cnt(b_cnt)
`endif
    );

    inv_input_network #(.N(64), .NSHIFT(5)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .y_in(c_y), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .x_out(c_x), .busy(c_busy)
`ifdef INV_INPUT_NETWORK_CNT_EN
        , .done_cnt(c_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Forward XOR-PUF input network: rotate x into z, then pairwise XORs of z.
    function automatic logic [63:0] fwd(input logic [63:0] x, input int n, input int sh);
        logic [63:0] z;
        logic [63:0] y;
        z = 64'h0;
        y = 64'h0;
        for (int k = 0; k < n; k++) z[k] = x[(k - sh + n) % n];
        y[n/2] = z[0];
        for (int i = 0; i <= n - 2; i++) begin
            if (i % 2 == 0) y[i/2] = z[i] ^ z[i+1];
            else            y[(n+i+1)/2] = z[i] ^ z[i+1];
        end
        return y;
    endfunction

    // Inverse for N=8 by exhaustive search of the forward network.
    function automatic logic [7:0] inv8(input logic [7:0] y, input int sh);
        logic [63:0] t;
        for (int v = 0; v < 256; v++) begin
            t = fwd(64'(v), 8, sh);
            if (t[7:0] == y) return 8'(v);
        end
        return 8'h00;
    endfunction

    // One full transaction on the N=8 pair with latency and result checks.
    task automatic run_a(input logic [7:0] y, input logic [7:0] ea, input logic [7:0] eb,
                         input string tag);
        int cyc;
        a_y = y;
        a_in_valid = 1'b1;
        check({tag, "_rdy"}, 64'(a_in_ready), 64'h1);
        tick();
        a_in_valid = 1'b0;
        a_y = ~y;
        check({tag, "_busy"}, 64'({a_busy, a_in_ready}), 64'h2);
        cyc = 0;
        while (!a_out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd8);
        check({tag, "_xa"}, 64'(a_x), 64'(ea));
        check({tag, "_xb"}, 64'({b_out_valid, b_x}), 64'({1'b1, eb}));
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check({tag, "_post"}, 64'({a_out_valid, a_in_ready}), 64'h1);
`ifdef INV_INPUT_NETWORK_CNT_EN
        a_hs++;
        check({tag, "_cnt"}, 64'(a_cnt), 64'(a_hs));
`endif
    endtask

    initial begin
        logic [7:0]  xr;
        logic [63:0] t, x64;
        int          seen, cyc;

        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_y = 8'h00;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_y = 64'h0;
        tick();
        tick();
        check("rst_a", 64'({a_in_ready, a_out_valid, a_busy, a_x}), 64'({3'b100, 8'h00}));
        check("rst_c", 64'({c_in_ready, c_out_valid, c_busy}), 64'h4);
        check("rst_cx", c_x, 64'h0);
        rst = 1'b0;
        tick();

        // Directed vectors.
        run_a(8'h11, 8'h01, 8'h80, "y11");
        run_a(8'hFF, 8'h55, 8'hAA, "yFF");
        run_a(8'h00, 8'h00, 8'h00, "y00");

        // Random round trips through the forward network.
        for (int r = 0; r < 10; r++) begin
            xr = 8'($urandom);
            t = fwd(64'(xr), 8, 0);
            run_a(t[7:0], xr, inv8(t[7:0], 1), "rnd8");
        end

        // Hold DONE with out_ready low while y_in/in_valid toggle.
        a_y = 8'h11;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        cyc = 0;
        while (!a_out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("hold_lat", 64'(cyc), 64'd8);
        for (int h = 0; h < 5; h++) begin
            a_y = 8'($urandom);
            a_in_valid = (h % 2 == 0);
            tick();
            check("hold", 64'({a_out_valid, a_in_ready, a_x}), 64'({2'b10, 8'h01}));
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
`ifdef INV_INPUT_NETWORK_CNT_EN
        a_hs++;
`endif
        seen = 0;
        for (int h = 0; h < 12; h++) begin
            tick();
            if (a_out_valid || a_busy) seen = 1;
        end
        check("no_recapture", 64'({seen[0], a_in_ready}), 64'h1);

        // Reset at step 3 of RECOVER aborts the challenge.
        a_y = 8'hFF;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        a_out_ready = 1'b1;
        tick();
        rst = 1'b0;
        a_out_ready = 1'b0;
        check("abort_rst", 64'({a_in_ready, a_out_valid, a_busy, a_x}), 64'({3'b100, 8'h00}));
`ifdef INV_INPUT_NETWORK_CNT_EN
        a_hs = 0;
        check("abort_cnt", 64'(a_cnt), 64'h0);
`endif
        seen = 0;
        for (int h = 0; h < 12; h++) begin
            tick();
            if (a_out_valid) seen = 1;
        end
        check("abort_nov", 64'(seen), 64'h0);
        run_a(8'h11, 8'h01, 8'h80, "after_abort");

        // N=64, NSHIFT=5 random round trips.
        for (int r = 0; r < 1000; r++) begin
            x64 = {$urandom, $urandom};
            c_y = fwd(x64, 64, 5);
            c_in_valid = 1'b1;
            cyc = 0;
            while (!c_in_ready && cyc < 10) begin
                tick();
                cyc++;
            end
            tick();
            c_in_valid = 1'b0;
            c_y = ~c_y;
            cyc = 0;
            while (!c_out_valid && cyc < 100) begin
                tick();
                cyc++;
            end
            check("c_lat", 64'(cyc), 64'd64);
            check("c_x", c_x, x64);
            tick();
        end
`ifdef INV_INPUT_NETWORK_CNT_EN
        check("c_cnt", 64'(c_cnt), 64'd1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
